// File: rtl/dual_boot_pkg.sv
// Shared encodings for the dual-configuration boot sequencer: FSM state codes,
// dual-config IP register map and the bit positions inside those registers.
package dual_boot_pkg;

  // FSM state codes; also exported unchanged on the probe vector.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POLL1 = 3'd1;
  localparam logic [2:0] ST_WSEL  = 3'd2;
  localparam logic [2:0] ST_POLL2 = 3'd3;
  localparam logic [2:0] ST_TRIG  = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  // Dual-config IP word addresses.
  localparam logic [2:0] ADDR_TRIG = 3'd0;
  localparam logic [2:0] ADDR_SEL  = 3'd1;
  localparam logic [2:0] ADDR_BUSY = 3'd2;

  // Bit positions inside the IP registers.
  localparam int BIT_TRIG    = 0;
  localparam int BIT_SEL_OVR = 0;
  localparam int BIT_SEL     = 1;
  localparam int BIT_BUSY    = 0;

  // Image-select word: overwrite enable plus the chosen image.
  function automatic logic [31:0] sel_word(input logic sel);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[BIT_SEL_OVR] = 1'b1;
    w[BIT_SEL]     = sel;
    return w;
  endfunction

  // Trigger word: only the reconfigure bit set.
  function automatic logic [31:0] trig_word();
    logic [31:0] w;
    w = 32'h0000_0000;
    w[BIT_TRIG] = 1'b1;
    return w;
  endfunction

  // A sequence is in flight in every state except IDLE and ERR.
  function automatic logic state_is_busy(input logic [2:0] st);
    return (st != ST_IDLE) && (st != ST_ERR);
  endfunction

endpackage

// File: rtl/dual_boot_seq_req_debounce.sv
// req_debounce: qualifies a request level. The level must be seen low at least
// once (armed) and then stay high for STABLE_CYC cycles; a single-cycle pulse is
// produced on the cycle the saturating counter reaches STABLE_CYC.
module req_debounce #(
  parameter int STABLE_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_level,
  output logic o_fire
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             fire_q, fire_d;

  // Next-state: saturating count while high, clear while low; arm on any low.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    fire_d  = 1'b0;
    if (i_level) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      // Pulse aligns with the cycle the count first shows CNT_MAX.
      fire_d = armed_q && (cnt_q == CNT_PRE);
    end else begin
      cnt_d   = {CNT_W{1'b0}};
      armed_d = 1'b1;
    end
  end

  // State registers; disarmed after reset so a level held through reset is ignored.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q   <= {CNT_W{1'b0}};
      armed_q <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      fire_q  <= fire_d;
    end
  end

  assign o_fire = fire_q;

endmodule

// File: rtl/dual_boot_seq.sv
// dual_boot_seq: drives the MAX10 dual-configuration IP through busy polling,
// image select, busy polling again and the reconfiguration trigger, then waits
// for the device to reload. All bus and status outputs come straight from flops.
module dual_boot_seq
  import dual_boot_pkg::*;
#(
  parameter int STABLE_CYC   = 16,
  parameter int RD_LAT       = 2,
  parameter int POLL_GAP     = 8,
  parameter int POLL_TIMEOUT = 1024,
  parameter int HOLD_CYC     = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_reconf_en,
  input  logic        i_conf_sel,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        o_busy,
  output logic        o_err,
  output logic [2:0]  o_state
);

  localparam int TMR_W  = $clog2(RD_LAT + POLL_GAP + 1);
  localparam int POLL_W = $clog2(POLL_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [TMR_W-1:0]  TMR_SAMPLE = TMR_W'(RD_LAT);
  localparam logic [TMR_W-1:0]  TMR_REREAD = TMR_W'(RD_LAT + POLL_GAP);
  localparam logic [POLL_W-1:0] POLL_MAX   = POLL_W'(POLL_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);

  logic              req_fire;
  logic [2:0]        state_q, state_d;
  logic              sel_q, sel_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [2:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  req_debounce #(.STABLE_CYC(STABLE_CYC)) u_debounce (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_level (i_reconf_en),
    .o_fire  (req_fire)
  );

  // Sequencer next-state and bus strobe generation.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tmr_d      = tmr_q;
    poll_cnt_d = poll_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (req_fire) begin
          // The image choice is frozen here; later i_conf_sel changes are ignored.
          sel_d      = i_conf_sel;
          err_d      = 1'b0;
          state_d    = ST_POLL1;
          rd_d       = 1'b1;
          addr_d     = ADDR_BUSY;
          tmr_d      = {TMR_W{1'b0}};
          poll_cnt_d = POLL_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POLL1, ST_POLL2: begin
        // tmr counts from the read strobe: sample at RD_LAT, re-read after the gap.
        if (tmr_q == TMR_SAMPLE) begin
          if (!avm_readdata[BIT_BUSY]) begin
            wr_d = 1'b1;
            if (state_q == ST_POLL1) begin
              state_d = ST_WSEL;
              addr_d  = ADDR_SEL;
              wdata_d = sel_word(sel_q);
            end else begin
              state_d = ST_TRIG;
              addr_d  = ADDR_TRIG;
              wdata_d = trig_word();
            end
          end else if (poll_cnt_q == POLL_MAX) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end else if (tmr_q == TMR_REREAD) begin
          rd_d       = 1'b1;
          addr_d     = ADDR_BUSY;
          tmr_d      = {TMR_W{1'b0}};
          poll_cnt_d = poll_cnt_q + POLL_W'(1);
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_WSEL: begin
        // poll_cnt restarts at 1 because the entry read is issued right away.
        state_d    = ST_POLL2;
        rd_d       = 1'b1;
        addr_d     = ADDR_BUSY;
        tmr_d      = {TMR_W{1'b0}};
        poll_cnt_d = POLL_W'(1);
      end
      ST_TRIG: begin
        state_d    = ST_HOLD;
        hold_cnt_d = {HOLD_W{1'b0}};
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        // Unused encoding: fail safe into the error state.
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    endcase
    busy_d = state_is_busy(state_d);
  end

  // Registered state, counters and outputs; reset forces the bus idle at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      tmr_q      <= {TMR_W{1'b0}};
      poll_cnt_q <= {POLL_W{1'b0}};
      hold_cnt_q <= {HOLD_W{1'b0}};
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 3'd0;
      wdata_q    <= 32'h0000_0000;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tmr_q      <= tmr_d;
      poll_cnt_q <= poll_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;
  assign o_busy        = busy_q;
  assign o_err         = err_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_dual_boot_seq.sv
// Bench for dual_boot_seq: a behavioural dual-config IP answers busy reads from
// a per-scenario plan and logs every bus transaction with its cycle number; each
// scenario predicts the transaction timeline from the protocol rules.
module tb_dual_boot_seq;

  localparam int STABLE = 16;
  localparam int RDL    = 2;
  localparam int GAP    = 8;
  localparam int PTO    = 4;
  localparam int HOLD   = 64;
  localparam int P      = RDL + GAP + 1;
  localparam int HIST   = 8192;

  typedef struct {
    int          c;
    logic [2:0]  a;
    logic [31:0] d;
  } xact_t;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        en   = 1'b0;
  logic        sel  = 1'b0;
  logic [2:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] rdata = 32'h0;
  logic        busy, err;
  logic [2:0]  st;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  xact_t rd_log[$];
  xact_t wr_log[$];
  bit    plan[$];
  logic [2:0] h_state [HIST];
  logic       h_busy  [HIST];
  logic       h_err   [HIST];
  int          bus_viol  = 0;
  int          resp_due  = -100;
  logic        resp_val  = 1'b0;
  logic [2:0]  last_addr = 3'd0;
  logic [31:0] last_data = 32'h0;

  dual_boot_seq #(
    .STABLE_CYC(STABLE), .RD_LAT(RDL), .POLL_GAP(GAP),
    .POLL_TIMEOUT(PTO), .HOLD_CYC(HOLD)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_reconf_en(en), .i_conf_sel(sel),
    .avm_address(addr), .avm_read(rd), .avm_write(wr),
    .avm_writedata(wdata), .avm_readdata(rdata),
    .o_busy(busy), .o_err(err), .o_state(st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // IP model and bus monitor: logs, checks hold rules, answers reads after RDL.
  initial begin : ip_model
    forever begin
      @(negedge clk);
      if (cyc < HIST) begin
        h_state[cyc] = st;
        h_busy[cyc]  = busy;
        h_err[cyc]   = err;
      end
      if (!rstn) begin
        last_addr = 3'd0;
        last_data = 32'h0;
      end else begin
        if (rd && wr) bus_viol++;
        if (rd) begin
          rd_log.push_back('{cyc, addr, wdata});
          if (wdata !== last_data) bus_viol++;
          last_addr = addr;
          resp_due  = cyc + RDL;
          resp_val  = (plan.size() > 0) ? plan.pop_front() : 1'b0;
        end else if (wr) begin
          wr_log.push_back('{cyc, addr, wdata});
          last_addr = addr;
          last_data = wdata;
        end else if (addr !== last_addr || wdata !== last_data) begin
          bus_viol++;
        end
      end
      // Outside the valid slot bit0 carries the opposite answer.
      rdata    = $urandom;
      rdata[0] = (cyc == resp_due) ? resp_val : ~resp_val;
    end
  end

  // Global time limit.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({rd, wr, busy, err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {rd, wr, busy, err});
    end
    n_tests++;
    if (addr !== 3'd0 || wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: got addr=%0d data=%h want 0/0", addr, wdata);
    end
    n_tests++;
    if (st !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", st);
    end
    @(negedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({st, busy} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_idle: got state=%0d busy=%b want 0/0", st, busy);
    end
  endtask

  // One full request: n1/n2 busy answers in the two poll phases, then HOLD expiry.
  task automatic run_and_check(input string name, input logic s_sel,
                               input int n1, input int n2, input bit retrig);
    int s, a, w, t, e;
    int exp_rd[$];
    plan.delete();
    repeat (n1) plan.push_back(1'b1);
    plan.push_back(1'b0);
    repeat (n2) plan.push_back(1'b1);
    plan.push_back(1'b0);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    rd_log.delete(); wr_log.delete();
    sel = s_sel; en = 1'b1; s = cyc;
    a = s + STABLE + 1;
    for (int k = 0; k <= n1; k++) exp_rd.push_back(a + k * P);
    w = a + n1 * P + RDL + 1;
    for (int k = 0; k <= n2; k++) exp_rd.push_back(w + 1 + k * P);
    t = w + 1 + n2 * P + RDL + 1;
    e = t + HOLD + 1;
    if (e + 6 >= HIST) begin
      $display("FAIL %s history: cycle %0d beyond log", name, e);
      $fatal(1, "history overflow");
    end
    wait_until(a);
    en = 1'b0;
    while (cyc < e + 4) begin
      @(negedge clk); #1;
      sel = 1'($urandom);
      if (retrig && cyc == a + 2) en = 1'b1;
    end
    n_tests++;
    if (rd_log.size() != exp_rd.size()) begin
      n_fail++; $display("FAIL %s read_count: got %0d want %0d", name, rd_log.size(), exp_rd.size());
    end
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) begin
      n_tests++;
      if (rd_log[i].c != exp_rd[i] || rd_log[i].a !== 3'd2) begin
        n_fail++;
        $display("FAIL %s read%0d: got cyc=%0d addr=%0d want cyc=%0d addr=2",
                 name, i, rd_log[i].c, rd_log[i].a, exp_rd[i]);
      end
    end
    n_tests++;
    if (wr_log.size() != 2) begin
      n_fail++; $display("FAIL %s write_count: got %0d want 2", name, wr_log.size());
    end else begin
      n_tests++;
      if (wr_log[0].c != w || wr_log[0].a !== 3'd1 || wr_log[0].d !== {30'b0, s_sel, 1'b1}) begin
        n_fail++;
        $display("FAIL %s sel_write: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=1 data=%h",
                 name, wr_log[0].c, wr_log[0].a, wr_log[0].d, w, {30'b0, s_sel, 1'b1});
      end
      n_tests++;
      if (wr_log[1].c != t || wr_log[1].a !== 3'd0 || wr_log[1].d !== 32'h1) begin
        n_fail++;
        $display("FAIL %s trig_write: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=0 data=1",
                 name, wr_log[1].c, wr_log[1].a, wr_log[1].d, t);
      end
    end
    n_tests++;
    if ({h_state[a], h_err[a]} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL %s accept: got state=%0d err=%b want 1/0", name, h_state[a], h_err[a]);
    end
    n_tests++;
    if ({h_state[t + 1], h_busy[t + 1]} !== {3'd5, 1'b1}) begin
      n_fail++; $display("FAIL %s hold_entry: got state=%0d busy=%b want 5/1", name, h_state[t + 1], h_busy[t + 1]);
    end
    n_tests++;
    if ({h_state[e - 1], h_state[e], h_err[e], h_busy[e]} !== {3'd5, 3'd6, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s hold_expiry: got st=%0d,%0d err=%b busy=%b want 5,6 1 0",
               name, h_state[e - 1], h_state[e], h_err[e], h_busy[e]);
    end
    n_tests++;
    if ({h_state[e + 1], h_err[e + 1], h_state[e + 3]} !== {3'd0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL %s err_to_idle: got st=%0d err=%b st3=%0d want 0 1 0",
               name, h_state[e + 1], h_err[e + 1], h_state[e + 3]);
    end
    n_tests++;
    if (bus_viol != 0) begin
      n_fail++; $display("FAIL %s bus_rules: got %0d violations want 0", name, bus_viol);
    end
  endtask

  task automatic test_timeout();
    int s, a, e;
    plan.delete();
    repeat (12) plan.push_back(1'b1);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    rd_log.delete(); wr_log.delete();
    sel = 1'($urandom); en = 1'b1; s = cyc;
    a = s + STABLE + 1;
    e = a + (PTO - 1) * P + RDL + 1;
    wait_until(e + 6);
    n_tests++;
    if (rd_log.size() != PTO || wr_log.size() != 0) begin
      n_fail++; $display("FAIL timeout_xacts: got reads=%0d writes=%0d want %0d/0", rd_log.size(), wr_log.size(), PTO);
    end
    for (int i = 0; i < PTO && i < rd_log.size(); i++) begin
      n_tests++;
      if (rd_log[i].c != a + i * P) begin
        n_fail++; $display("FAIL timeout_read%0d: got cyc=%0d want %0d", i, rd_log[i].c, a + i * P);
      end
    end
    n_tests++;
    if ({h_state[e], h_err[e], h_busy[e]} !== {3'd6, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL timeout_err: got st=%0d err=%b busy=%b want 6 1 0", h_state[e], h_err[e], h_busy[e]);
    end
    n_tests++;
    if ({h_state[e + 1], h_err[e + 1], h_state[e + 5], h_err[e + 5]} !== {3'd0, 1'b1, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_sticky: got st=%0d err=%b st5=%0d err5=%b want 0 1 0 1",
               h_state[e + 1], h_err[e + 1], h_state[e + 5], h_err[e + 5]);
    end
    run_and_check("timeout_recover", 1'b1, 0, 1, 1'b0);
  endtask

  task automatic test_short_pulse();
    int s, len;
    int any_busy;
    for (int p = 0; p < 2; p++) begin
      len = (p == 0) ? 10 : STABLE - 1;
      @(negedge clk); en = 1'b0;
      @(negedge clk);
      rd_log.delete(); wr_log.delete();
      s = cyc; en = 1'b1;
      repeat (len) @(negedge clk);
      en = 1'b0;
      wait_until(s + 40);
      any_busy = 0;
      for (int c = s; c <= s + 40; c++) if (h_busy[c] !== 1'b0) any_busy++;
      n_tests++;
      if (rd_log.size() != 0 || wr_log.size() != 0 || any_busy != 0 || st !== 3'd0) begin
        n_fail++;
        $display("FAIL short_pulse_%0d: got reads=%0d writes=%0d busy_cycles=%0d state=%0d want 0 0 0 0",
                 len, rd_log.size(), wr_log.size(), any_busy, st);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s, a;
    int any_busy;
    plan.delete();
    plan.push_back(1'b0);
    repeat (10) plan.push_back(1'b1);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    sel = 1'b1; en = 1'b1; s = cyc;
    a = s + STABLE + 1;
    wait_until(a + 4 + P);
    n_tests++;
    if ({st, rd} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL mid_poll2_read: got st=%0d rd=%b want 3/1", st, rd);
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({rd, wr, busy, err, st, addr} !== 9'd0 || wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got rd=%b wr=%b busy=%b err=%b st=%0d addr=%0d data=%h want all 0",
               rd, wr, busy, err, st, addr, wdata);
    end
    @(negedge clk); #1;
    rd_log.delete(); wr_log.delete();
    rstn = 1'b1; s = cyc;
    wait_until(s + 40);
    any_busy = 0;
    for (int c = s + 1; c <= s + 40; c++) if (h_busy[c] !== 1'b0) any_busy++;
    n_tests++;
    if (rd_log.size() != 0 || wr_log.size() != 0 || any_busy != 0) begin
      n_fail++;
      $display("FAIL held_level_after_reset: got reads=%0d writes=%0d busy_cycles=%0d want 0 0 0",
               rd_log.size(), wr_log.size(), any_busy);
    end
    run_and_check("after_reset", 1'b0, 0, 0, 1'b0);
  endtask

  initial begin : main
    test_reset();
    run_and_check("basic_sel1", 1'b1, 0, 0, 1'b0);
    run_and_check("basic_sel0", 1'b0, 0, 0, 1'b0);
    run_and_check("busy_poll", 1'b1, 3, 0, 1'b0);
    run_and_check("poll_boundary", 1'b0, PTO - 1, PTO - 1, 1'b1);
    test_timeout();
    test_short_pulse();
    test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      run_and_check("random", 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
